mux_scan_sequencer: RTL and testbench
=====================================

# mux_scan_sequencer

Upstream sequencing stage for `mux_16x1`. It accepts a parallel word on a valid/ready handshake and holds it on the mux `data_inputs` bus. It steps `select_lines` through every position, one per accepted output beat, and returns the mux's `mux_output` as a serial bit stream with valid/ready/last framing. The result is a parallel-to-serial converter built around the existing combinational mux.

## Interface
- `WIDTH`, 16, word width; must equal the mux data width, ≥2, ≤2**SEL_W
- `SEL_W`, 4, select width driven to the mux
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  parallel word offered
- `in_ready`  out  1  word can be accepted this cycle
- `in_data`  in  WIDTH  parallel word
- `in_lsb_first`  in  1  scan order, sampled with the word: 1 = index 0 upward, 0 = index WIDTH-1 downward
- `data_inputs`  out  WIDTH  registered word to the mux
- `select_lines`  out  SEL_W  registered mux select
- `mux_output`  in  1  combinational mux result
- `out_valid`  out  1  serial bit valid
- `out_bit`  out  1  serial bit, equal to `mux_output`
- `out_last`  out  1  final bit of the word
- `out_ready`  in  1  downstream accepts the bit
- `busy`  out  1  a word is being scanned

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - SHIFT: `out_valid`=1, `busy`=1.
- Load (`in_valid && in_ready`):
  - `data_inputs` ← `in_data`.
  - The order flag is registered.
  - `select_lines` ← 0 if `in_lsb_first`, else WIDTH-1.
  - The FSM moves to SHIFT.
- SHIFT:
  - `out_bit` = `mux_output`, with no register.
  - `out_last` = (`select_lines` == WIDTH-1 when LSB-first, == 0 when MSB-first).
- Beat (`out_valid && out_ready`, not last): `select_lines` steps by +1 for LSB-first or −1 for MSB-first. It never wraps inside a word.
- Last beat accepted:
  - If `in_valid` is high in the same cycle, the new word loads and the FSM stays in SHIFT. This gives zero-bubble back-to-back operation.
  - Otherwise the FSM returns to IDLE.
- `in_ready` = IDLE | (SHIFT & `out_last` & `out_ready`).
- Stall: with `out_ready`=0, `select_lines`, `data_inputs` and `out_bit` hold stable, and `out_valid` stays high.
- `in_data` changes while busy are ignored. `data_inputs` changes only on load.
- In IDLE, `select_lines` and `data_inputs` keep their last values, which avoids needless mux toggling.

## Timing
- Reset values: `data_inputs`=0, `select_lines`=0, state=IDLE, `out_valid`=0, `out_last`=0, `in_ready`=1, `busy`=0.
- Reset asserted mid-word: the word is abandoned, the outputs take their reset values immediately, and nothing resumes after release.
- Load accepted at edge N: the first bit is valid in the cycle after N.
- The full word takes WIDTH cycles at `out_ready`=1. The last bit is in cycle N+WIDTH.
- Sustained throughput is 1 bit/cycle across words.
- `out_bit` is combinational through the external mux, so the downstream samples it on the same edge as `out_ready`.

## Structure
- Package `mux_scan_pkg`:
  - State enum {IDLE, SHIFT}.
  - Default WIDTH/SEL_W constants.
- Natural sub-module `scan_sel_counter`:
  - Loadable up/down counter, SEL_W bits.
  - Load value 0 or WIDTH-1; enable; direction.
  - Terminal-count output used as `out_last`.
- The mux itself stays external. The bench instantiates `mux_16x1` and wires `data_inputs`, `select_lines` and `mux_output` back to this block.

## Test plan
- Reset then idle: after `rst_n` is released, `in_ready`=1, `out_valid`=0, `select_lines`=0, `data_inputs`=0.
- Load 16'hA55A with LSB-first and `out_ready` held 1:
  - Bits 0,1,0,1,1,0,1,0,1,0,1,0,0,1,0,1 on 16 consecutive cycles.
  - `out_last` only on the 16th beat.
  - `select_lines` reads 0..15.
- Load 16'h8001 with MSB-first:
  - Bits 1, fourteen 0s, 1.
  - `select_lines` reads 15..0, with `out_last` at select 0.
- Backpressure: 16'hF0F0 with `out_ready` toggling 1,0,0,1,…
  - Stalled cycles hold `select_lines` and `out_bit` constant.
  - Exactly 16 accepted beats, in order.
- Back-to-back: 16'hFFFF then 16'h0000 offered continuously. The second word loads on the first word's last-beat edge, giving 32 contiguous valid beats with no bubble.
- Reset mid-word: `rst_n` is pulsed low after 5 beats of 16'h1234.
  - `out_valid` drops asynchronously and `select_lines` becomes 0.
  - After release, a fresh 16'h00FF scans correctly from its first bit.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and default sizing for the mux scan sequencer.
package mux_scan_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } scan_state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEL_W = 4;

endpackage

// File: rtl/mux_16x1.sv
// Existing combinational 16:1 mux that the sequencer scans.
module mux_16x1 (
    input  logic [15:0] data_inputs,
    input  logic [3:0]  select_lines,
    output logic        mux_output
);

    assign mux_output = data_inputs[select_lines];

endmodule

// File: rtl/scan_sel_counter.sv
// Loadable up/down select counter; terminal count marks the final scan position.
module scan_sel_counter #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             load_max_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [SEL_W-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [SEL_W-1:0] CNT_MAX = SEL_W'(WIDTH - 1);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_max_i ? CNT_MAX : '0;
        end else if (en_i) begin
            cnt_d = up_i ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal position depends on scan direction; enable is never raised past it.
    assign tc_o  = up_i ? (cnt_q == CNT_MAX) : (cnt_q == '0);
    assign cnt_o = cnt_q;

endmodule

// File: rtl/mux_scan_sequencer.sv
// Parallel-to-serial sequencer driving an external 16:1 mux with valid/ready/last framing.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_lsb_first,
    output logic [WIDTH-1:0] data_inputs,
    output logic [SEL_W-1:0] select_lines,
    input  logic             mux_output,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    scan_state_e      state_q;
    logic [WIDTH-1:0] data_q;
    logic             lsb_first_q;

    logic             tc;
    logic             shifting;
    logic             load;
    logic             beat;
    logic             last_beat;

    assign shifting  = (state_q == ST_SHIFT);
    assign last_beat = shifting && tc && out_ready;
    assign in_ready  = !shifting || last_beat;
    assign load      = in_valid && in_ready;
    assign beat      = shifting && out_ready && !tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            lsb_first_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        state_q     <= ST_SHIFT;
                        data_q      <= in_data;
                        lsb_first_q <= in_lsb_first;
                    end
                end
                ST_SHIFT: begin
                    // A word offered on the last beat loads immediately, with no bubble.
                    if (load) begin
                        data_q      <= in_data;
                        lsb_first_q <= in_lsb_first;
                    end else if (last_beat) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    scan_sel_counter #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_sel_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .load_max_i (!in_lsb_first),
        .en_i       (beat),
        .up_i       (lsb_first_q),
        .cnt_o      (select_lines),
        .tc_o       (tc)
    );

    assign data_inputs = data_q;
    assign out_valid   = shifting;
    assign busy        = shifting;
    assign out_last    = shifting && tc;
    assign out_bit     = mux_output;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer wired around mux_16x1.
module tb_mux_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_lsb_first = 1'b1;
    logic [15:0] data_inputs;
    logic [3:0]  select_lines;
    logic        mux_output;
    logic        out_valid;
    logic        out_bit;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_scan_sequencer #(.WIDTH(16), .SEL_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_lsb_first (in_lsb_first),
        .data_inputs  (data_inputs),
        .select_lines (select_lines),
        .mux_output   (mux_output),
        .out_valid    (out_valid),
        .out_bit      (out_bit),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    mux_16x1 u_mux (
        .data_inputs  (data_inputs),
        .select_lines (select_lines),
        .mux_output   (mux_output)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Offers one word from idle, then checks every beat against the hand-written
    // serial stream (bit k = k-th emitted bit). bp selects the 1,0,0,1 ready pattern.
    task automatic run_word(input logic [15:0] word, input logic lsb,
                            input logic [15:0] stream, input logic bp);
        int k   = 0;
        int cyc = 0;
        in_data      = word;
        in_lsb_first = lsb;
        in_valid     = 1'b1;
        out_ready    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~word;
        while (k < 16 && cyc < 80) begin
            chk("valid", 32'(out_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("sel", 32'(select_lines), lsb ? 32'(k) : 32'(15 - k));
            chk("bit", 32'(out_bit), 32'(stream[k]));
            chk("last", 32'(out_last), 32'(k == 15));
            chk("din", 32'(data_inputs), 32'(word));
            out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            chk("in_ready", 32'(in_ready), 32'(k == 15 && out_ready));
            @(posedge clk);
            if (out_ready) k++;
            cyc++;
            @(negedge clk);
        end
        chk("beats", 32'(k), 32'd16);
        out_ready = 1'b1;
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_sel", 32'(select_lines), lsb ? 32'd15 : 32'd0);
        chk("idle_din", 32'(data_inputs), 32'(word));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'(select_lines), 32'd0);
        chk("rst_din", 32'(data_inputs), 32'd0);

        run_word(16'hA55A, 1'b1, 16'hA55A, 1'b0);
        run_word(16'h8001, 1'b0, 16'h8001, 1'b0);
        run_word(16'hF0F0, 1'b1, 16'hF0F0, 1'b1);
        // MSB-first 0x1234 emits bits 15..0 -> stream 0x2C48
        run_word(16'h1234, 1'b0, 16'h2C48, 1'b1);

        // Back-to-back: FFFF then 0000 with in_valid held; 32 contiguous beats.
        in_data      = 16'hFFFF;
        in_lsb_first = 1'b1;
        in_valid     = 1'b1;
        out_ready    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = 16'h0000;
        for (int k = 0; k < 32; k++) begin
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_bit", 32'(out_bit), (k < 16) ? 32'd1 : 32'd0);
            chk("b2b_sel", 32'(select_lines), 32'(k % 16));
            chk("b2b_din", 32'(data_inputs), (k < 16) ? 32'hFFFF : 32'h0000);
            chk("b2b_ready", 32'(in_ready), 32'(k == 15 || k == 31));
            @(posedge clk);
            @(negedge clk);
            if (k == 15) in_valid = 1'b0;
        end
        chk("b2b_end", 32'(out_valid), 32'd0);

        // Reset mid-word: 5 beats of 0x1234 LSB-first (0,0,1,0,1), then abandon.
        in_data      = 16'h1234;
        in_lsb_first = 1'b1;
        in_valid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("mid_bit", 32'(out_bit), (k == 2 || k == 4) ? 32'd1 : 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_sel", 32'(select_lines), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_sel", 32'(select_lines), 32'd0);
        chk("arst_din", 32'(data_inputs), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_sel", 32'(select_lines), 32'd0);

        run_word(16'h00FF, 1'b1, 16'h00FF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
